// File: rtl/clk_div_seq_pkg.sv
// Shared types, constants and helpers for the divider select sequencer.
package clk_div_seq_pkg;

  localparam int unsigned DW          = 8;
  localparam logic [1:0]  DEFAULT_SEL = 2'b00;
  localparam int unsigned MASK_CYC    = 2;
  localparam int unsigned MASK_W      = $clog2(MASK_CYC + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_LOW = 2'd2,
    DONE     = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]    sel;
    logic [DW-1:0] dwell;
    logic          en;
  } entry_t;

  typedef struct packed {
    logic       wrapped;
    logic [1:0] idx;
  } next_t;

  // First enabled entry after cur (cur itself last); wrapped set when the search passed index 3.
  function automatic next_t next_enabled(input logic [1:0] cur, input logic [3:0] en_vec);
    next_t      r;
    logic [2:0] pos;
    r.wrapped = 1'b0;
    r.idx     = cur;
    for (int k = 4; k >= 1; k--) begin
      pos = 3'(cur) + 3'(k);
      if (en_vec[pos[1:0]]) begin
        r.idx     = pos[1:0];
        r.wrapped = pos[2];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_div_sequencer_edge.sv
// Rising-edge detector on the divided clock, blind for MASK_CYC cycles after a select change.
module div_edge_detect
  import clk_div_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic mask_start,
  output logic rise_c
);

  logic              prev;
  logic [MASK_W-1:0] mask_cnt;

  // Previous sample and settle-mask countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= 1'b0;
      mask_cnt <= '0;
    end else begin
      prev <= sig;
      if (mask_start) begin
        mask_cnt <= MASK_W'(MASK_CYC);
      end else if (mask_cnt != '0) begin
        mask_cnt <= mask_cnt - MASK_W'(1);
      end
    end
  end

  assign rise_c = sig & ~prev & (mask_cnt == '0);

endmodule

// File: rtl/clk_div_sequencer.sv
// Steps the divider select through a 4-entry dwell schedule, switching only while the divided clock is low.
module clk_div_sequencer
  import clk_div_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_idx,
  input  logic [1:0]    cfg_sel,
  input  logic [DW-1:0] cfg_dwell,
  input  logic          cfg_en,
  input  logic          div_clk_in,
  output logic [1:0]    div_sel,
  output logic          busy,
  output logic [1:0]    step_idx,
  output logic          switch_pulse,
  output logic          done,
  output logic          cfg_err
);

  localparam int unsigned CW = DW + 1;

  state_e        state, state_n;
  entry_t        tbl [4];
  logic [DW-1:0] cnt, cnt_n;
  logic [DW-1:0] dwell_q, dwell_n;
  logic          loop_q, loop_n;
  logic [1:0]    sel_n, idx_n;
  logic          switch_n;
  logic [3:0]    en_vec;
  next_t         nxt;
  logic [DW:0]   cnt_plus;
  logic          rise_c;

  div_edge_detect u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig        (div_clk_in),
    .mask_start (switch_n),
    .rise_c     (rise_c)
  );

  // Enable vector gathered from the table for the next-entry search.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      en_vec[i] = tbl[i].en;
    end
  end

  // Next state, next select and counter updates.
  always_comb begin
    state_n  = state;
    sel_n    = div_sel;
    idx_n    = step_idx;
    cnt_n    = cnt;
    dwell_n  = dwell_q;
    loop_n   = loop_q;
    switch_n = 1'b0;
    cnt_plus = {1'b0, cnt} + CW'(1);
    // From IDLE the search starts past index 3, i.e. at the lowest enabled entry.
    nxt      = next_enabled((state == IDLE) ? 2'd3 : step_idx, en_vec);
    case (state)
      IDLE: begin
        if (start && !stop && (en_vec != 4'b0000)) begin
          idx_n    = nxt.idx;
          sel_n    = tbl[nxt.idx].sel;
          dwell_n  = (tbl[nxt.idx].dwell == '0) ? DW'(1) : tbl[nxt.idx].dwell;
          cnt_n    = '0;
          loop_n   = mode;
          switch_n = 1'b1;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (rise_c) begin
          cnt_n = cnt_plus[DW-1:0];
          if (cnt_plus == {1'b0, dwell_q}) begin
            state_n = WAIT_LOW;
          end
        end
      end
      WAIT_LOW: begin
        if (stop) begin
          state_n = IDLE;
        end else if (!div_clk_in) begin
          if (!loop_q && nxt.wrapped) begin
            state_n = DONE;
          end else begin
            idx_n    = nxt.idx;
            sel_n    = tbl[nxt.idx].sel;
            dwell_n  = (tbl[nxt.idx].dwell == '0) ? DW'(1) : tbl[nxt.idx].dwell;
            cnt_n    = '0;
            switch_n = 1'b1;
            state_n  = RUN;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, schedule registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dwell_q      <= DW'(1);
      loop_q       <= 1'b0;
      div_sel      <= DEFAULT_SEL;
      step_idx     <= 2'd0;
      busy         <= 1'b0;
      switch_pulse <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      dwell_q      <= dwell_n;
      loop_q       <= loop_n;
      div_sel      <= sel_n;
      step_idx     <= idx_n;
      busy         <= (state_n == RUN) || (state_n == WAIT_LOW);
      switch_pulse <= switch_n;
      done         <= (state_n == DONE);
      cfg_err      <= cfg_we & busy;
    end
  end

  // Schedule table; writes while a schedule runs are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        tbl[i] <= '{sel: 2'b00, dwell: DW'(1), en: 1'b0};
      end
    end else if (cfg_we && !busy) begin
      tbl[cfg_idx] <= '{sel: cfg_sel, dwell: cfg_dwell, en: cfg_en};
    end
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Randomized bench for clk_div_sequencer with a schedule-level reference model.
`timescale 1ns/1ps
module tb_clk_div_sequencer;
  import clk_div_seq_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic          cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0]    cfg_idx = 2'd0, cfg_sel = 2'd0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          div_clk_in;
  logic [1:0]    div_sel, step_idx;
  logic          busy, switch_pulse, done, cfg_err;

  logic          force_hi = 1'b0;
  logic [7:0]    dcnt = 8'd0;
  int            n_checks = 0;
  int            n_errors = 0;

  clk_div_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_dwell(cfg_dwell),
    .cfg_en(cfg_en), .div_clk_in(div_clk_in), .div_sel(div_sel), .busy(busy),
    .step_idx(step_idx), .switch_pulse(switch_pulse), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Divider stand-in: period 32 >> sel clock cycles, optionally forced high.
  always @(posedge clk) dcnt <= dcnt + 8'd1;
  always_comb begin
    case (div_sel)
      2'd0:    div_clk_in = force_hi | dcnt[4];
      2'd1:    div_clk_in = force_hi | dcnt[3];
      2'd2:    div_clk_in = force_hi | dcnt[2];
      default: div_clk_in = force_hi | dcnt[1];
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 counting rises, 2 waiting for low clock, 3 completion cycle.
  int         ph = 0;
  int         m_idx = 0, m_remain = 0, m_mask = 0;
  logic [1:0] m_sel = DEFAULT_SEL;
  bit         m_loop = 0, m_prev = 0;
  int         t_sel [4] = '{0, 0, 0, 0};
  int         t_dw  [4] = '{1, 1, 1, 1};
  bit         t_en  [4] = '{0, 0, 0, 0};
  bit         e_sw = 0, e_done = 0, e_err = 0, e_busy = 0;
  bit         md, mr, msw, mbusy, many, mfound;
  int         mpos;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0; m_idx = 0; m_remain = 0; m_mask = 0; m_sel = DEFAULT_SEL;
      m_loop = 0; m_prev = 0;
      for (int i = 0; i < 4; i++) begin t_sel[i] = 0; t_dw[i] = 1; t_en[i] = 0; end
      e_sw = 0; e_done = 0; e_err = 0; e_busy = 0;
    end else begin
      md = div_clk_in;
      mr = md && !m_prev && (m_mask == 0);
      m_prev = md;
      msw = 0;
      mbusy = (ph == 1) || (ph == 2);
      e_err = cfg_we && mbusy;
      many = t_en[0] || t_en[1] || t_en[2] || t_en[3];
      case (ph)
        0: if (start && !stop && many) begin
             mfound = 0;
             for (int j = 0; j < 4; j++) if (!mfound && t_en[j]) begin m_idx = j; mfound = 1; end
             m_sel = 2'(t_sel[m_idx]); m_remain = eff(t_dw[m_idx]);
             m_loop = mode; msw = 1; ph = 1;
           end
        1: if (stop) ph = 0;
           else if (mr) begin
             m_remain--;
             if (m_remain == 0) ph = 2;
           end
        2: if (stop) ph = 0;
           else if (!md) begin
             mfound = 0; mpos = 0;
             for (int k = 1; k <= 4; k++) if (!mfound && t_en[(m_idx + k) % 4]) begin
               mpos = m_idx + k; mfound = 1;
             end
             if (!m_loop && mpos > 3) ph = 3;
             else begin
               m_idx = mpos % 4; m_sel = 2'(t_sel[m_idx]); m_remain = eff(t_dw[m_idx]);
               msw = 1; ph = 1;
             end
           end
        default: ph = 0;
      endcase
      if (cfg_we && !mbusy) begin
        t_sel[cfg_idx] = int'(cfg_sel); t_dw[cfg_idx] = int'(cfg_dwell); t_en[cfg_idx] = cfg_en;
      end
      m_mask = msw ? int'(MASK_CYC) : ((m_mask > 0) ? m_mask - 1 : 0);
      e_sw = msw; e_done = (ph == 3); e_busy = (ph == 1) || (ph == 2);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("div_sel", 32'(div_sel), 32'(m_sel));
      check("step_idx", 32'(step_idx), 32'(m_idx));
      check("busy", 32'(busy), 32'(e_busy));
      check("switch_pulse", 32'(switch_pulse), 32'(e_sw));
      check("done", 32'(done), 32'(e_done));
      check("cfg_err", 32'(cfg_err), 32'(e_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  int done_seen = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input int sel, input int dw, input bit en);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_sel = 2'(sel); cfg_dwell = DW'(dw); cfg_en = en;
    tick();
    cfg_we = 0;
  endtask

  task automatic start_pulse(input bit m);
    mode = m; start = 1;
    tick();
    start = 0;
  endtask

  task automatic stop_pulse();
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic wait_sw(input int budget);
    bit hit;
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (done) done_seen++;
      if (switch_pulse) hit = 1;
    end
    check("wait_switch_timeout", 32'(hit), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int nsw);
    bit hit;
    hit = 0; nsw = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (switch_pulse) nsw++;
      if (done) hit = 1;
    end
    check("wait_done_timeout", 32'(hit), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_div_sel"}, 32'(div_sel), 32'(DEFAULT_SEL));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_step_idx"}, 32'(step_idx), 32'd0);
    check({tag, "_switch"}, 32'(switch_pulse), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  int nsw, cnt_sw;

  initial begin
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1;
    tick();

    // Reset mid-run clears outputs and table.
    wr(0, 3, 4, 1);
    start_pulse(0);
    check("t1_sel", 32'(div_sel), 32'd3);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_switch", 32'(switch_pulse), 32'd1);
    repeat ($urandom_range(5, 60)) tick();
    rst_n = 0;
    #1;
    chk_reset_vals("t1_async");
    tick();
    rst_n = 1;
    tick();
    start_pulse(0);
    check("t1_cleared_busy", 32'(busy), 32'd0);
    check("t1_cleared_switch", 32'(switch_pulse), 32'd0);

    // Single pass over entries 0 and 2.
    wr(0, 0, 3, 1);
    wr(2, 3, 1, 1);
    start_pulse(0);
    check("t2_sel0", 32'(div_sel), 32'd0);
    check("t2_idx0", 32'(step_idx), 32'd0);
    wait_sw(400);
    check("t2_sel1", 32'(div_sel), 32'd3);
    check("t2_idx1", 32'(step_idx), 32'd2);
    wait_done(200, nsw);
    check("t2_no_extra_switch", 32'(nsw), 32'd0);
    check("t2_sel_at_done", 32'(div_sel), 32'd3);
    tick();
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_done_once", 32'(done), 32'd0);
    check("t2_sel_hold", 32'(div_sel), 32'd3);

    // Loop over entries 0 and 3.
    wr(0, 1, 1, 1);
    wr(2, 0, 1, 0);
    wr(3, 2, 2, 1);
    done_seen = 0;
    start_pulse(1);
    check("t3_sel_a", 32'(div_sel), 32'd1);
    wait_sw(300); check("t3_sel_b", 32'(div_sel), 32'd2);
    wait_sw(300); check("t3_sel_c", 32'(div_sel), 32'd1);
    wait_sw(300); check("t3_sel_d", 32'(div_sel), 32'd2);
    check("t3_no_done", 32'(done_seen), 32'd0);
    stop_pulse();
    check("t3_stop_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    check("t3_stop_hold", 32'(div_sel), 32'd2);

    // Dwell 0 behaves as 1.
    wr(0, 0, 1, 0);
    wr(3, 0, 1, 0);
    wr(1, 3, 0, 1);
    start_pulse(0);
    check("t4_sel", 32'(div_sel), 32'd3);
    check("t4_idx", 32'(step_idx), 32'd1);
    wait_done(200, nsw);
    check("t4_no_switch", 32'(nsw), 32'd0);
    check("t4_sel_done", 32'(div_sel), 32'd3);
    tick();

    // Illegal operations.
    wr(1, 0, 1, 0);
    wr(0, 1, 5, 1);
    start_pulse(0);
    tick();
    wr(0, 2, 1, 1);
    check("t5_cfg_err", 32'(cfg_err), 32'd1);
    stop_pulse();
    tick();
    start_pulse(0);
    check("t5_table_kept", 32'(div_sel), 32'd1);
    stop_pulse();
    wr(0, 1, 5, 0);
    check("t5_idle_no_err", 32'(cfg_err), 32'd0);
    start_pulse(0);
    check("t5_none_busy", 32'(busy), 32'd0);
    check("t5_none_switch", 32'(switch_pulse), 32'd0);
    wr(0, 1, 5, 1);
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    check("t5_ss_busy", 32'(busy), 32'd0);
    check("t5_ss_switch", 32'(switch_pulse), 32'd0);

    // Divided clock held high blocks the switch.
    wr(0, 0, 1, 1);
    wr(1, 1, 1, 1);
    start_pulse(1);
    repeat (3) tick();
    force_hi = 1;
    cnt_sw = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (switch_pulse) cnt_sw++;
    end
    check("t6_no_switch_forced", 32'(cnt_sw), 32'd0);
    check("t6_sel_forced", 32'(div_sel), 32'd0);
    force_hi = 0;
    wait_sw(100);
    check("t6_sel_after", 32'(div_sel), 32'd1);
    stop_pulse();
    tick();

    // Randomized traffic checked by the model.
    for (int c = 0; c < 5000; c++) begin
      start     = ($urandom_range(0, 29) == 0);
      stop      = ($urandom_range(0, 199) == 0);
      mode      = 1'($urandom_range(0, 1));
      cfg_we    = ($urandom_range(0, 24) == 0);
      cfg_idx   = 2'($urandom_range(0, 3));
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_dwell = DW'($urandom_range(0, 3));
      cfg_en    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) force_hi = ~force_hi;
      tick();
    end
    start = 0; stop = 0; cfg_we = 0; force_hi = 0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
